switch_merge: RTL and testbench

- Reverse-direction companion to the address switch: takes the two switch output streams (port A, port B) and merges them back onto one vld/addr/data stream.
- Each input has a small FIFO. Non-empty FIFOs are arbitrated round-robin.
- The output stage is registered and uses valid/ready handshaking. Input items that arrive while their FIFO is full are dropped and counted.
- Used as a loopback/recombine stage and as the transmit-side model for the switch testbench.

---
 rtl/switch_merge.sv | 131 +++++++++++++
 tb/tb_switch_merge.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_merge.sv
// switch_merge: recombines the two address-switch output streams (port A and
// port B) onto a single vld/rdy stream. Each input is buffered in a small
// circular FIFO. Non-empty FIFOs are served round-robin into a registered
// output stage. Items that arrive at a full FIFO are dropped and counted.
module switch_merge #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  vld_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic                  vld_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic                  vld,
    input  logic                  rdy,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  src,
    output logic                  full_a,
    output logic                  full_b,
    output logic [7:0]            drop_cnt_a,
    output logic [7:0]            drop_cnt_b
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ITEM_W = ADDR_WIDTH + DATA_WIDTH;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [ITEM_W-1:0] mem_a [FIFO_DEPTH];
    logic [ITEM_W-1:0] mem_b [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_a, rd_ptr_a;
    logic [PTR_W-1:0]  wr_ptr_b, rd_ptr_b;
    logic [CNT_W-1:0]  cnt_a, cnt_b;
    logic [CNT_W-1:0]  cnt_a_nxt, cnt_b_nxt;
    logic              last_grant;   // 0 = A won last, 1 = B won last
    logic              load;
    logic              push_a, push_b;
    logic              pop_a, pop_b;

    // Push/pop decisions; the full check uses the pre-edge count, so a pop in
    // the same cycle never makes room for an incoming item.
    always_comb begin
        load   = !vld || rdy;
        push_a = vld_a && (cnt_a != DEPTH_C);
        push_b = vld_b && (cnt_b != DEPTH_C);
        pop_a  = 1'b0;
        pop_b  = 1'b0;
        if (load) begin
            if ((cnt_a != '0) && ((cnt_b == '0) || last_grant)) begin
                pop_a = 1'b1;
            end else if (cnt_b != '0) begin
                pop_b = 1'b1;
            end
        end
        cnt_a_nxt = cnt_a + CNT_W'(push_a) - CNT_W'(pop_a);
        cnt_b_nxt = cnt_b + CNT_W'(push_b) - CNT_W'(pop_b);
    end

    // FIFO storage; contents need no reset because the pointers and counts do.
    always_ff @(posedge clk) begin
        if (push_a) begin
            mem_a[wr_ptr_a] <= {addr_a, data_a};
        end
        if (push_b) begin
            mem_b[wr_ptr_b] <= {addr_b, data_b};
        end
    end

    // FIFO pointers, counts, full flags and saturating drop counters.
    always_ff @(posedge clk) begin
        if (rstn) begin
            wr_ptr_a   <= '0;
            rd_ptr_a   <= '0;
            wr_ptr_b   <= '0;
            rd_ptr_b   <= '0;
            cnt_a      <= '0;
            cnt_b      <= '0;
            full_a     <= 1'b0;
            full_b     <= 1'b0;
            drop_cnt_a <= 8'd0;
            drop_cnt_b <= 8'd0;
        end else begin
            if (push_a) wr_ptr_a <= wr_ptr_a + PTR_W'(1);
            if (pop_a)  rd_ptr_a <= rd_ptr_a + PTR_W'(1);
            if (push_b) wr_ptr_b <= wr_ptr_b + PTR_W'(1);
            if (pop_b)  rd_ptr_b <= rd_ptr_b + PTR_W'(1);
            cnt_a  <= cnt_a_nxt;
            cnt_b  <= cnt_b_nxt;
            full_a <= (cnt_a_nxt == DEPTH_C);
            full_b <= (cnt_b_nxt == DEPTH_C);
            if (vld_a && !push_a && (drop_cnt_a != 8'hFF)) begin
                drop_cnt_a <= drop_cnt_a + 8'd1;
            end
            if (vld_b && !push_b && (drop_cnt_b != 8'hFF)) begin
                drop_cnt_b <= drop_cnt_b + 8'd1;
            end
        end
    end

    // Registered output stage: reload when empty or when the current item
    // transfers; addr/data/src hold when nothing is available to load.
    always_ff @(posedge clk) begin
        if (rstn) begin
            vld        <= 1'b0;
            addr       <= '0;
            data       <= '0;
            src        <= 1'b0;
            last_grant <= 1'b1;
        end else if (load) begin
            if (pop_a) begin
                vld          <= 1'b1;
                {addr, data} <= mem_a[rd_ptr_a];
                src          <= 1'b0;
                last_grant   <= 1'b0;
            end else if (pop_b) begin
                vld          <= 1'b1;
                {addr, data} <= mem_b[rd_ptr_b];
                src          <= 1'b1;
                last_grant   <= 1'b1;
            end else begin
                vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_switch_merge.sv
// Testbench for switch_merge: directed vector table, hand-written corner
// sequences (full/drop/saturation, backpressure, mid-stream reset) and a
// randomized run compared against a queue-based reference model.
module tb_switch_merge;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        vld_a, vld_b, rdy;
    logic [7:0]  addr_a, addr_b;
    logic [15:0] data_a, data_b;
    logic        vld, src, full_a, full_b;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [7:0]  drop_cnt_a, drop_cnt_b;

    int checks   = 0;
    int failures = 0;

    switch_merge dut (
        .clk(clk), .rstn(rstn),
        .vld_a(vld_a), .addr_a(addr_a), .data_a(data_a),
        .vld_b(vld_b), .addr_b(addr_b), .data_b(data_b),
        .vld(vld), .rdy(rdy), .addr(addr), .data(data), .src(src),
        .full_a(full_a), .full_b(full_b),
        .drop_cnt_a(drop_cnt_a), .drop_cnt_b(drop_cnt_b)
    );

    always #5 clk = ~clk;

    // Reference model: plain queues plus the output register contents.
    logic [23:0] qa[$];
    logic [23:0] qb[$];
    logic        m_vld = 1'b0, m_src = 1'b0, m_last = 1'b1;
    logic [7:0]  m_addr = 8'd0;
    logic [15:0] m_data = 16'd0;
    logic        m_full_a = 1'b0, m_full_b = 1'b0;
    logic [7:0]  m_drop_a = 8'd0, m_drop_b = 8'd0;

    function automatic void model_step();
        int na;
        int nb;
        logic [23:0] item;
        na = qa.size();
        nb = qb.size();
        if (rstn) begin
            qa.delete();
            qb.delete();
            m_vld = 1'b0; m_addr = 8'd0; m_data = 16'd0; m_src = 1'b0;
            m_last = 1'b1;
            m_full_a = 1'b0; m_full_b = 1'b0;
            m_drop_a = 8'd0; m_drop_b = 8'd0;
        end else begin
            if (!m_vld || rdy) begin
                if (na > 0 && (nb == 0 || m_last)) begin
                    item = qa.pop_front();
                    m_vld = 1'b1; {m_addr, m_data} = item; m_src = 1'b0; m_last = 1'b0;
                end else if (nb > 0) begin
                    item = qb.pop_front();
                    m_vld = 1'b1; {m_addr, m_data} = item; m_src = 1'b1; m_last = 1'b1;
                end else begin
                    m_vld = 1'b0;
                end
            end
            if (vld_a) begin
                if (na < DEPTH) qa.push_back({addr_a, data_a});
                else if (m_drop_a != 8'hFF) m_drop_a = m_drop_a + 8'd1;
            end
            if (vld_b) begin
                if (nb < DEPTH) qb.push_back({addr_b, data_b});
                else if (m_drop_b != 8'hFF) m_drop_b = m_drop_b + 8'd1;
            end
            m_full_a = (qa.size() == DEPTH);
            m_full_b = (qb.size() == DEPTH);
        end
    endfunction

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        vld_a = 1'b0; addr_a = 8'd0; data_a = 16'd0;
        vld_b = 1'b0; addr_b = 8'd0; data_b = 16'd0;
    endtask

    typedef struct {
        logic        rst;
        logic        va;
        logic [7:0]  aa;
        logic [15:0] da;
        logic        vb;
        logic [7:0]  ab;
        logic [15:0] db;
        logic        rdy;
        logic        ev;
        logic [7:0]  ea;
        logic [15:0] ed;
        logic        es;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs[NVEC];

    initial begin
        // rst va aa da vb ab db rdy | exp vld addr data src
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0};
        for (int i = 2; i <= 6; i++)
            vecs[i] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0};
        // single item: no bypass, one cycle visible, then empty
        vecs[7]  = '{1'b0, 1'b1, 8'h11, 16'hAAAA, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h00, 16'h0000, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'h11, 16'hAAAA, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'h11, 16'hAAAA, 1'b0};
        // reset restores last_grant = B, then round-robin with stall
        vecs[10] = '{1'b1, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 8'hA1, 16'd1, 1'b1, 8'hB1, 16'd101, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 8'hA2, 16'd2, 1'b1, 8'hB2, 16'd102, 1'b0, 1'b1, 8'hA1, 16'd1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 8'hA3, 16'd3, 1'b1, 8'hB3, 16'd103, 1'b0, 1'b1, 8'hA1, 16'd1, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'hA1, 16'd1, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b1, 8'hA1, 16'd1, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'hB1, 16'd101, 1'b1};
        vecs[17] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'hA2, 16'd2, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'hB2, 16'd102, 1'b1};
        vecs[19] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'hA3, 16'd3, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b1, 8'hB3, 16'd103, 1'b1};
        vecs[21] = '{1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 8'hB3, 16'd103, 1'b1};

        rstn = 1'b1;
        rdy  = 1'b1;
        idle_inputs();

        // Directed vector table
        for (int i = 0; i < NVEC; i++) begin
            rstn   = vecs[i].rst;
            vld_a  = vecs[i].va; addr_a = vecs[i].aa; data_a = vecs[i].da;
            vld_b  = vecs[i].vb; addr_b = vecs[i].ab; data_b = vecs[i].db;
            rdy    = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d_out", i),
                  64'({vld, addr, data, src}),
                  64'({vecs[i].ev, vecs[i].ea, vecs[i].ed, vecs[i].es}));
            check($sformatf("vec%0d_flags", i),
                  64'({full_a, full_b, drop_cnt_a, drop_cnt_b}), 64'(0));
        end

        // Full and drop: 6 pushes with rdy=0 -> one item in output, four buffered, one dropped
        rstn = 1'b1; idle_inputs(); rdy = 1'b0;
        tick();
        rstn = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            vld_a = 1'b1; addr_a = 8'(i); data_a = 16'(i);
            tick();
        end
        idle_inputs();
        check("full_a_after6", 64'(full_a), 64'(1));
        check("drop_a_after6", 64'(drop_cnt_a), 64'(1));
        check("out_after6", 64'({vld, data, src}), 64'({1'b1, 16'd1, 1'b0}));
        check("full_b_idle", 64'(full_b), 64'(0));

        // Saturation of the drop counter
        for (int i = 0; i < 260; i++) begin
            vld_a = 1'b1; addr_a = 8'hEE; data_a = 16'hF000;
            tick();
        end
        idle_inputs();
        check("drop_a_sat", 64'(drop_cnt_a), 64'(255));

        // Backpressure: output must hold while rdy=0
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d", i), 64'({vld, addr, data, src}),
                  64'({1'b1, 8'd1, 16'd1, 1'b0}));
        end

        // Drain: exactly one item per clock, in order, no duplication
        rdy = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            tick();
            check($sformatf("drain%0d", k), 64'({vld, addr, data, src}),
                  64'({1'b1, 8'(k), 16'(k), 1'b0}));
        end
        tick();
        check("drain_empty", 64'(vld), 64'(0));
        check("drain_flags", 64'({full_a, drop_cnt_a}), 64'({1'b0, 8'hFF}));

        // Mid-stream reset discards buffered and output contents
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vld_a = 1'b1; addr_a = 8'h50 + 8'(i); data_a = 16'h5000 + 16'(i);
            vld_b = 1'b1; addr_b = 8'h60 + 8'(i); data_b = 16'h6000 + 16'(i);
            tick();
        end
        vld_a = 1'b1; vld_b = 1'b1; rstn = 1'b1;
        tick();
        idle_inputs(); rstn = 1'b0;
        check("rst_mid_out", 64'({vld, addr, data, src}), 64'(0));
        check("rst_mid_flags", 64'({full_a, full_b, drop_cnt_a, drop_cnt_b}), 64'(0));
        rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("rst_no_stale%0d", i), 64'(vld), 64'(0));
        end

        // Randomized run against the reference model
        begin
            int rdy_pct;
            int va_pct;
            int vb_pct;
            rdy_pct = 60; va_pct = 50; vb_pct = 50;
            for (int c = 0; c < 3000; c++) begin
                if (c % 100 == 0) begin
                    rdy_pct = int'($urandom_range(10, 100));
                    va_pct  = int'($urandom_range(0, 90));
                    vb_pct  = int'($urandom_range(0, 90));
                end
                rstn   = ($urandom_range(0, 399) == 0);
                rdy    = (int'($urandom_range(0, 99)) < rdy_pct);
                vld_a  = (int'($urandom_range(0, 99)) < va_pct);
                vld_b  = (int'($urandom_range(0, 99)) < vb_pct);
                addr_a = 8'($urandom()); data_a = 16'($urandom());
                addr_b = 8'($urandom()); data_b = 16'($urandom());
                tick();
                check($sformatf("rand%0d", c),
                      64'({vld, src, addr, data, full_a, full_b, drop_cnt_a, drop_cnt_b}),
                      64'({m_vld, m_src, m_addr, m_data, m_full_a, m_full_b, m_drop_a, m_drop_b}));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
